axi_bram_rd_slave: RTL and testbench
====================================

# axi_bram_rd_slave

AXI4 read-only responder backed by an on-chip synchronous-read BRAM, used as boot/simulation instruction memory behind the I-cache's AR/R master port. It accepts one burst at a time, streams beats in order with full `rready` backpressure, and sustains one beat per cycle. A side write port preloads the memory.

## Interface
Parameters:
- `LEN_ADDR`, 12 — log2 of memory depth in 32-bit words (16 KB).
- `BASE`, 32'h1fc0_0000 — physical base address; low `LEN_ADDR+2` bits must be zero.

Ports:
- `clk` in 1 — sole clock.
- `resetn` in 1 — reset, synchronous, active-low.
- `araddr` in 32 — burst start byte address.
- `arlen` in 8 — beats minus one (0..255).
- `arsize` in 3 — must be 3'd2.
- `arburst` in 2 — 0 FIXED, 1 INCR; 2/3 handled as INCR.
- `arvalid` in 1 / `arready` out 1 — AR handshake.
- `rdata` out 32, `rresp` out 2, `rlast` out 1 — R payload.
- `rvalid` out 1 / `rready` in 1 — R handshake.
- `mem_we` in 1, `mem_waddr` in `LEN_ADDR`, `mem_wdata` in 32 — preload write, word addressed.

## Operation
- States: IDLE, BURST.
- IDLE: `arready`=1. On `arvalid&arready`, latch word pointer `araddr[LEN_ADDR+1:2]`, `arlen`, `arburst`, and range flag `in_range = (araddr[31:LEN_ADDR+2] == BASE[31:LEN_ADDR+2])`; go to BURST; `arready`=0.
- BURST: BRAM read port issues one fetch per cycle while `occupancy + inflight - pop < 2`, where occupancy is the 2-entry output FIFO count, inflight is a fetch issued last cycle, and pop is `rvalid&rready`. Fetch counter stops after `arlen+1` fetches.
- Pointer update per fetch: INCR adds 1 modulo 2^`LEN_ADDR` (wraps inside memory); FIXED holds.
- Each beat carries `rlast` = (beat index == `arlen`). Out-of-range burst: every beat `rdata`=0, `rresp`=2'b10 (SLVERR), no memory dependence; otherwise `rresp`=2'b00.
- `arsize`≠2 is not checked; treated as 2.
- Burst ends on the handshake of the `rlast` beat; next cycle state is IDLE and `arready`=1. No AR accepted during BURST (single outstanding).
- `mem_we` writes in any state. Same-cycle write and fetch of one word returns old data (read-first).

## Timing
- Reset (`resetn`=0 at a clock edge): next cycle `arready`=1, `rvalid`=0, `rlast`=0, `rresp`=0, `rdata`=0, FIFO empty, fetch counters 0, state IDLE. Reset mid-burst drops the burst; memory contents are retained.
- AR handshake in cycle T; first fetch in T+1; beat 0 `rvalid`=1 in T+2.
- With `rready` held high, beats appear in T+2 .. T+2+`arlen`, one per cycle, with no bubbles.
- `rready` low: `rvalid`, `rdata`, `rresp`, `rlast` hold stable until accepted. After `rready` rises, the stream resumes at one beat per cycle with no bubble.
- `arlen`=0: a single beat at T+2 with `rlast`=1; `arready`=1 at T+3 if accepted at T+2.

## Structure
- Shared package (`defines.vh`): AXI burst constants `BURST_FIXED`/`BURST_INCR`, response constants `RESP_OKAY`/`RESP_SLVERR`.
- Memory: existing `dual_port_bram_nobw` (port A preload write, port B fetch read).
- One natural sub-module: `axi_r_fifo2`, a 2-entry FIFO of {`rdata`,`rresp`,`rlast`} with count output.

## Test plan
- Preload words 0..15 with `32'hA000_0000+i`; INCR `araddr`=`BASE`, `arlen`=15, `rready`=1 -> 16 beats on consecutive cycles T+2..T+17, `rdata` = `A000_0000..A000_000F`, `rlast` only on the 16th beat, `arready`=1 at T+18.
- Same burst with `rready` toggling 1,0,0,1,... -> no beat lost or duplicated, order preserved, payload stable while stalled.
- FIXED burst at `BASE+8`, `arlen`=3 -> 4 beats all = word 2.
- INCR at last word of memory, `arlen`=1 -> beats = last word, then word 0.
- `araddr`=`32'h0000_0000` (out of range), `arlen`=2 -> 3 beats, `rdata`=0, `rresp`=2'b10.
- `resetn` low during beat 5 of 16 -> next cycle `rvalid`=0, `arready`=1; a new burst then completes correctly.

Source files
------------

// File: rtl/axi_bram_rd_slave_pkg.sv
// Shared constants and types for the AXI4 BRAM read responder.
// Covers burst encodings, response codes, the FSM state type and the R beat width.
package axi_bram_rd_slave_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One R beat as stored in the output FIFO: {rdata, rresp, rlast}
    localparam int RBEAT_W = 35;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

endpackage

// File: rtl/axi_r_fifo2.sv
// Two-entry R-beat FIFO with a fall-through path.
// When empty, a beat being pushed is presented on the output in the same cycle.
module axi_r_fifo2 #(
    parameter int W = 35
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    logic w_empty;
    logic w_bypass;
    logic w_store;
    logic w_drop;

    assign w_empty  = (r_count == 2'd0);
    // An empty FIFO whose incoming beat is consumed at once never stores it
    assign w_bypass = i_push & w_empty & i_pop;
    assign w_store  = i_push & ~w_bypass;
    assign w_drop   = i_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_store) r_wptr <= ~r_wptr;
            if (w_drop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_store} - {1'b0, w_drop};
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wptr] <= i_data;
    end

    assign o_valid = ~w_empty | i_push;
    assign o_data  = !w_empty ? r_mem[r_rptr] : (i_push ? i_data : '0);
    assign o_count = r_count;

endmodule

// File: rtl/axi_bram_rd_slave.sv
// AXI4 read-only responder backed by a synchronous-read BRAM with a preload port.
// One burst at a time, one beat per cycle, full rready backpressure.
module axi_bram_rd_slave
    import axi_bram_rd_slave_pkg::*;
#(
    parameter int          LEN_ADDR = 12,
    parameter logic [31:0] BASE     = 32'h1fc0_0000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    input  logic                mem_we,
    input  logic [LEN_ADDR-1:0] mem_waddr,
    input  logic [31:0]         mem_wdata,
    output logic                dbg_state
);

    localparam int DEPTH = 1 << LEN_ADDR;

    state_t              r_state;
    state_t              w_state_nx;
    logic [LEN_ADDR-1:0] r_ptr;
    logic [7:0]          r_len;
    logic                r_fixed;
    logic                r_in_range;
    logic [8:0]          r_fetch_cnt;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [31:0]         r_bram_q;
    logic [31:0]         r_mem [DEPTH];

    logic               w_ar_hs;
    logic               w_pop;
    logic               w_room;
    logic               w_fetch;
    logic               w_fetch_done;
    logic               w_fetch_last;
    logic [1:0]         w_count;
    logic [RBEAT_W-1:0] w_push_data;
    logic [RBEAT_W-1:0] w_head;
    logic               w_unused;

    assign arready      = (r_state == ST_IDLE);
    assign w_ar_hs      = arvalid & arready;
    assign w_pop        = rvalid & rready;
    assign w_fetch_done = (r_fetch_cnt == ({1'b0, r_len} + 9'd1));
    // Issue only if the beat fetched now is guaranteed a FIFO slot when it lands
    assign w_room       = ({1'b0, w_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
    assign w_fetch      = (r_state == ST_BURST) & ~w_fetch_done & w_room;
    assign w_fetch_last = (r_fetch_cnt[7:0] == r_len);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (w_ar_hs) w_state_nx = ST_BURST;
            ST_BURST: if (w_pop && rlast) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_len           <= 8'd0;
            r_fixed         <= 1'b0;
            r_in_range      <= 1'b0;
            r_fetch_cnt     <= 9'd0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state         <= w_state_nx;
            r_inflight      <= w_fetch;
            r_inflight_last <= w_fetch & w_fetch_last;
            if (w_ar_hs) begin
                r_ptr       <= araddr[LEN_ADDR+1:2];
                r_len       <= arlen;
                r_fixed     <= (arburst == BURST_FIXED);
                r_in_range  <= (araddr[31:LEN_ADDR+2] == BASE[31:LEN_ADDR+2]);
                r_fetch_cnt <= 9'd0;
            end else if (w_fetch) begin
                r_fetch_cnt <= r_fetch_cnt + 9'd1;
                if (!r_fixed) r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    // Read-first: a same-cycle write to the fetched word returns the old value
    always_ff @(posedge clk) begin
        if (mem_we)  r_mem[mem_waddr] <= mem_wdata;
        if (w_fetch) r_bram_q <= r_mem[r_ptr];
    end

    assign w_push_data = {r_in_range ? r_bram_q : 32'd0,
                          r_in_range ? RESP_OKAY : RESP_SLVERR,
                          r_inflight_last};

    axi_r_fifo2 #(.W(RBEAT_W)) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (r_inflight),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_valid (rvalid),
        .o_data  (w_head),
        .o_count (w_count)
    );

    assign {rdata, rresp, rlast} = w_head;
    assign dbg_state = r_state;
    // arsize is always treated as 4 bytes; byte offset bits carry no meaning
    assign w_unused = ^{arsize, araddr[1:0]};

endmodule

// File: tb/tb_axi_bram_rd_slave.sv
// Self-checking bench for axi_bram_rd_slave: a model builds expected R beats per
// burst into a queue, and a negedge monitor compares every presented beat.
module tb_axi_bram_rd_slave;

    localparam int          LEN_ADDR  = 12;
    localparam int          DEPTH     = 1 << LEN_ADDR;
    localparam logic [31:0] BASE_ADDR = 32'h1fc0_0000;

    logic                clk;
    logic                resetn;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;
    logic                mem_we;
    logic [LEN_ADDR-1:0] mem_waddr;
    logic [31:0]         mem_wdata;
    logic                dbg_state;

    axi_bram_rd_slave #(.LEN_ADDR(LEN_ADDR), .BASE(BASE_ADDR)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [34:0] exp_q[$];
    logic [31:0] model_mem [DEPTH];

    int neg_cyc   = 0;
    int t_ar      = -10;
    int beat_idx  = 0;
    bit timing_chk = 1'b0;
    bit prev_stall = 1'b0;
    bit last_popped = 1'b0;
    int rr_mode = 0;
    int rr_idx  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // rready pattern: 0 = always high, 1 = 1,0,0 repeating, 2 = random
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       rready = 1'b1;
                1:       rready = ((rr_idx % 3) == 0);
                default: rready = 1'(($urandom_range(0, 1)));
            endcase
            rr_idx++;
        end
    end

    // scoreboard monitor
    always @(negedge clk) begin
        neg_cyc++;
        if (!resetn) begin
            prev_stall  = 1'b0;
            last_popped = 1'b0;
        end else begin
            if (last_popped) check("arready_after_last", arready, 1);
            last_popped = 1'b0;
            if (prev_stall) check("rvalid_hold", rvalid, 1);
            if (arvalid && arready) begin
                t_ar     = neg_cyc;
                beat_idx = 0;
            end
            if (neg_cyc == t_ar + 1) check("arready_busy", arready, 0);
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", rvalid, 0);
                end else begin
                    check("beat", {rdata, rresp, rlast}, exp_q[0]);
                    if (rready) begin
                        if (timing_chk) check("beat_cycle", neg_cyc, t_ar + 2 + beat_idx);
                        void'(exp_q.pop_front());
                        beat_idx++;
                        if (rlast) last_popped = 1'b1;
                    end
                end
            end
            prev_stall = rvalid && !rready;
        end
    end

    // driver tasks (called in the posedge+1 phase)
    task automatic write_word(input int a, input logic [31:0] d);
        mem_we    = 1'b1;
        mem_waddr = LEN_ADDR'(a);
        mem_wdata = d;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic send_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int          ptr;
        bit          inr;
        logic [31:0] d;
        ptr = int'(addr[LEN_ADDR+1:2]);
        inr = (addr[31:LEN_ADDR+2] == BASE_ADDR[31:LEN_ADDR+2]);
        for (int i = 0; i <= int'(len); i++) begin
            d = inr ? model_mem[ptr] : 32'd0;
            exp_q.push_back({d, inr ? 2'b00 : 2'b10, (i == int'(len))});
            if (burst != 2'd0) ptr = (ptr + 1) % DEPTH;
        end
        araddr  = addr;
        arlen   = len;
        arburst = burst;
        arsize  = 3'd2;
        arvalid = 1'b1;
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || !arready) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("burst_drained", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        araddr    = 32'd0;
        arlen     = 8'd0;
        arsize    = 3'd2;
        arburst   = 2'd1;
        arvalid   = 1'b0;
        rready    = 1'b1;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", arready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_state", dbg_state, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < 16; i++) write_word(i, 32'hA000_0000 + i);
        for (int i = 16; i < 32; i++) write_word(i, $urandom);
        write_word(DEPTH - 1, 32'hBEEF_0FFF);

        // full-rate INCR burst of 16
        rr_mode = 0; timing_chk = 1'b1;
        send_burst(BASE_ADDR, 8'd15, 2'd1);
        wait_idle(100);

        // same burst under 1,0,0 backpressure
        rr_mode = 1; timing_chk = 1'b0;
        send_burst(BASE_ADDR, 8'd15, 2'd1);
        wait_idle(200);

        // FIXED burst on word 2
        rr_mode = 0; timing_chk = 1'b1;
        send_burst(BASE_ADDR + 32'd8, 8'd3, 2'd0);
        wait_idle(100);

        // INCR wrapping from the last word to word 0
        send_burst(BASE_ADDR + 32'(4 * (DEPTH - 1)), 8'd1, 2'd1);
        wait_idle(100);

        // out-of-range burst
        send_burst(32'h0000_0000, 8'd2, 2'd1);
        wait_idle(100);

        // single beat
        send_burst(BASE_ADDR + 32'd12, 8'd0, 2'd1);
        wait_idle(100);

        // reset during beat 5 of 16
        send_burst(BASE_ADDR, 8'd15, 2'd1);
        begin
            int n = 0;
            while (beat_idx < 5 && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("mid_reset_reach", beat_idx, 5);
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_reset_rvalid", rvalid, 0);
        check("mid_reset_arready", arready, 1);
        @(posedge clk);
        #1;
        send_burst(BASE_ADDR + 32'd64, 8'd7, 2'd1);
        wait_idle(100);

        // random bursts with random backpressure
        rr_mode = 2; timing_chk = 1'b0;
        for (int k = 0; k < 8; k++) begin
            send_burst(BASE_ADDR + 32'(4 * $urandom_range(0, 24)),
                       8'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            wait_idle(200);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
